regfile_port_ctrl: RTL
======================

REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, operand/register data width; REG_NUM, default 32, register count; AW = clog2(REG_NUM), derived address width.
REQ-002 clk  in  1  single clock; all state updates on the posedge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req_valid  in  1  operand-fetch request valid.
REQ-005 req_ready  out  1  request accepted when high together with req_valid.
REQ-006 req_rs1, req_rs2, req_rd  in  AW each  source and destination register numbers.
REQ-007 rf_rs1_addr, rf_rs2_addr  out  AW each  register-file read addresses; the file returns data one cycle later.
REQ-008 rf_rs1_data, rf_rs2_data  in  DATA_WIDTH each  registered read data from the register file.
REQ-009 rf_rd_addr  out  AW, rf_rd_data  out  DATA_WIDTH, rf_rd_wren  out  1: register-file write port.
REQ-010 wb_valid  in  1, wb_addr  in  AW, wb_data  in  DATA_WIDTH: writeback from execute; always accepted.
REQ-011 op_valid  out  1, op_ready  in  1: operand output handshake.
REQ-012 op_rs1_data, op_rs2_data  out  DATA_WIDTH, op_rd  out  AW: registered operand bundle.

Function
REQ-013 States SHALL be IDLE, FETCH and VALID; a transfer SHALL occur on each edge where the valid and its ready are both high.
REQ-014 rf_rs1_addr and rf_rs2_addr SHALL equal req_rs1 and req_rs2 combinationally in every cycle.
REQ-015 rf_rd_wren SHALL equal wb_valid AND NOT rst; rf_rd_addr SHALL equal wb_addr and rf_rd_data SHALL equal wb_data, all combinationally.
REQ-016 The scoreboard SHALL hold one pending bit per register; bit 0 SHALL always read 0.
REQ-017 A source or destination register is a hazard when its pending bit is set and no wb_valid with wb_addr equal to it is present in the same cycle.
REQ-018 req_ready SHALL be high only when the state is IDLE, or the state is VALID and op_ready is high, and no req_rs1, req_rs2 or req_rd hazard exists.
REQ-019 On accept, the state SHALL go to FETCH and req_rd SHALL be latched; if req_rd is not 0, its pending bit SHALL be set.
REQ-020 On accept, each source SHALL latch a bypass flag and wb_data when wb_valid is high, wb_addr equals that source, and the source is not 0.
REQ-021 In FETCH, each operand SHALL be the latched wb_data when its bypass flag is set, otherwise rf_rsN_data; the operands SHALL be registered into op_*.
REQ-022 From FETCH, the state SHALL go to VALID and op_valid SHALL rise on the next edge; the minimum latency is 2 cycles from accept to op_valid.
REQ-023 In VALID, op_* SHALL hold stable until op_ready is high. Then the state SHALL go to FETCH if a new request is accepted on the same edge, otherwise to IDLE.
REQ-024 wb_valid with a nonzero wb_addr SHALL clear that pending bit. If the same edge also sets that bit through REQ-019, the set SHALL win.
REQ-025 wb_valid with wb_addr equal to 0 SHALL pass to the write port and SHALL NOT change the scoreboard.
REQ-026 A source equal to 0 SHALL never be a hazard and SHALL never be bypassed.
REQ-027 Throughput SHALL be at most one request per 2 cycles; back-to-back issue through VALID to FETCH SHALL be supported.

Reset
REQ-028 While rst is high: state IDLE, all pending bits 0, op_valid 0, op_rs1_data and op_rs2_data 0, op_rd 0, bypass flags 0, rf_rd_wren 0.
REQ-029 rst asserted in FETCH or VALID SHALL discard the in-flight request without emitting op_valid.
REQ-030 The first accept SHALL be possible on the first edge after rst deasserts.

Verification
REQ-031 Write then read: wb x5=0xDEADBEEF at cycle 0; request rs1=5, rs2=0, rd=6 at cycle 2 -> op_rs1_data=0xDEADBEEF, op_rs2_data=0, op_rd=6, op_valid at cycle 4.
REQ-032 RAW hazard: request rd=7 accepted; next request rs1=7 -> req_ready stays 0 until wb x7=0x1234 arrives. Then it is accepted on that cycle with bypass, giving op_rs1_data=0x1234.
REQ-033 Same-cycle bypass: wb x3=0xAA coincident with accept of rs2=3 -> op_rs2_data=0xAA, not the stale register-file value.
REQ-034 Backpressure: op_ready held 0 for 5 cycles in VALID -> op_* unchanged and req_ready 0 throughout. op_ready=1 with a pending request -> the request is accepted on the same edge.
REQ-035 x0 rules: request rd=0 then rs1=0 -> no stall and operand 0. wb to x0 -> rf_rd_wren=1 and no scoreboard change.
REQ-036 Reset mid-FETCH: rst pulses with rd=9 pending -> op_valid stays 0, and a following request with rs1=9 is accepted immediately.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl
//   Operand-fetch front end for a register file. Accepts a request naming two
//   source registers and one destination, reads the sources from a register
//   file with one cycle of read latency, and presents a registered operand
//   bundle on a valid/ready handshake. A per-register pending scoreboard stalls
//   requests that touch a register whose result is still outstanding, and a
//   writeback arriving in the same cycle as an accept is bypassed into the
//   operands (the register file read would otherwise return the stale value).
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_rs1/req_rs2/req_rd    source and destination register numbers
//   rf_rs1_addr/rf_rs2_addr   register-file read addresses (data next cycle)
//   rf_rs1_data/rf_rs2_data   registered read data from the register file
//   rf_rd_addr/_data/_wren    register-file write port (driven by writeback)
//   wb_valid/wb_addr/wb_data  writeback from execute, always accepted
//   op_valid/op_ready         operand bundle handshake
//   op_rs1_data/op_rs2_data   operand values
//   op_rd                     destination register of the bundle
module regfile_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  localparam int AW        = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_rs1,
  input  logic [AW-1:0]         req_rs2,
  input  logic [AW-1:0]         req_rd,
  output logic [AW-1:0]         rf_rs1_addr,
  output logic [AW-1:0]         rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  output logic [AW-1:0]         rf_rd_addr,
  output logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  rf_rd_wren,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_rs1_data,
  output logic [DATA_WIDTH-1:0] op_rs2_data,
  output logic [AW-1:0]         op_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [AW-1:0] X0 = {AW{1'b0}};

  state_t                  state;
  state_t                  state_next;
  logic [REG_NUM-1:0]      pending;
  logic [REG_NUM-1:0]      pending_next;
  logic [AW-1:0]           rd_lat;
  logic                    byp1;
  logic                    byp2;
  logic [DATA_WIDTH-1:0]   byp1_data;
  logic [DATA_WIDTH-1:0]   byp2_data;
  logic                    req_hazard;
  logic                    slot_free;
  logic                    accept;

  // A register is a hazard while pending, unless its result is being written
  // back in this very cycle (then it can be taken through the bypass).
  function automatic logic is_hazard(input logic [REG_NUM-1:0] pend,
                                     input logic [AW-1:0]      r,
                                     input logic               wv,
                                     input logic [AW-1:0]      wa);
    return pend[r] & ~(wv & (wa == r));
  endfunction

  assign rf_rs1_addr = req_rs1;
  assign rf_rs2_addr = req_rs2;
  assign rf_rd_addr  = wb_addr;
  assign rf_rd_data  = wb_data;
  assign rf_rd_wren  = wb_valid & ~rst;

  assign req_hazard = is_hazard(pending, req_rs1, wb_valid, wb_addr)
                    | is_hazard(pending, req_rs2, wb_valid, wb_addr)
                    | is_hazard(pending, req_rd,  wb_valid, wb_addr);
  // The output slot is free when idle, or when the current bundle leaves now.
  assign slot_free  = (state == IDLE) | ((state == VALID) & op_ready);
  assign req_ready  = slot_free & ~req_hazard;
  assign accept     = req_valid & req_ready;

  // Next-state selection for the fetch sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = FETCH;
        else        state_next = IDLE;
      end
      FETCH: begin
        state_next = VALID;
      end
      VALID: begin
        if (op_ready) state_next = accept ? FETCH : IDLE;
        else          state_next = VALID;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scoreboard update: writeback clears, accept sets (set wins), x0 never pending.
  always_comb begin
    pending_next = pending;
    if (wb_valid && (wb_addr != X0)) pending_next[wb_addr] = 1'b0;
    else                             pending_next = pending_next;
    if (accept && (req_rd != X0))    pending_next[req_rd] = 1'b1;
    else                             pending_next = pending_next;
    pending_next[0] = 1'b0;
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= {REG_NUM{1'b0}};
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  // Request capture: destination and same-cycle writeback bypass per source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_lat    <= X0;
      byp1      <= 1'b0;
      byp2      <= 1'b0;
      byp1_data <= {DATA_WIDTH{1'b0}};
      byp2_data <= {DATA_WIDTH{1'b0}};
    end else if (accept) begin
      rd_lat    <= req_rd;
      byp1      <= wb_valid & (wb_addr == req_rs1) & (req_rs1 != X0);
      byp2      <= wb_valid & (wb_addr == req_rs2) & (req_rs2 != X0);
      byp1_data <= wb_data;
      byp2_data <= wb_data;
    end
  end

  // Operand bundle: loaded once in FETCH, held until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid    <= 1'b0;
      op_rs1_data <= {DATA_WIDTH{1'b0}};
      op_rs2_data <= {DATA_WIDTH{1'b0}};
      op_rd       <= X0;
    end else if (state == FETCH) begin
      op_valid    <= 1'b1;
      op_rs1_data <= byp1 ? byp1_data : rf_rs1_data;
      op_rs2_data <= byp2 ? byp2_data : rf_rs2_data;
      op_rd       <= rd_lat;
    end else if ((state == VALID) && op_ready) begin
      op_valid    <= 1'b0;
    end
  end

endmodule
